// File: rtl/column_pkg.sv
// column_pkg: shared constants and helpers for the column gatherer.
//   NUM_COLS       - column words per assembled row
//   COL_W          - width of the column index
//   ROW_FIFO_DEPTH - assembled rows buffered ahead of the consumer
//   row_w()        - width of one assembled row for a given column width
package column_pkg;

    localparam int unsigned NUM_COLS       = 4;
    localparam int unsigned COL_W          = 2;
    localparam int unsigned ROW_FIFO_DEPTH = 2;

    // Row word is NUM_COLS column words side by side, column 0 in the low lane.
    function automatic int unsigned row_w(input int unsigned data_w);
        return NUM_COLS * data_w;
    endfunction

endpackage

// File: rtl/column_gather_if.sv
// column_gather_if: column input handshake plus assembled-row output handshake.
//   col_idx/col_data/col_valid/col_ready - column word stream into the gatherer
//   row_data/row_valid/row_ready         - assembled row stream out of the gatherer
//   master: producer/consumer side (testbench); slave: the gatherer.
interface column_gather_if #(
    parameter int unsigned DATA_W = 8
);
    import column_pkg::*;

    localparam int unsigned ROW_W = row_w(DATA_W);

    logic [COL_W-1:0]  col_idx;
    logic [DATA_W-1:0] col_data;
    logic              col_valid;
    logic              col_ready;
    logic [ROW_W-1:0]  row_data;
    logic              row_valid;
    logic              row_ready;

    modport master (
        output col_idx, col_data, col_valid, row_ready,
        input  col_ready, row_data, row_valid
    );

    modport slave (
        input  col_idx, col_data, col_valid, row_ready,
        output col_ready, row_data, row_valid
    );

endinterface

// File: rtl/row_fifo.sv
// row_fifo: two-entry row buffer, entry 0 is always the head.
//   clk, reset    - clock, synchronous active-high reset
//   push/push_data- write a row (ignored when full)
//   pop           - drop the head row (ignored when empty)
//   head_data     - current head row (registered)
//   full, empty   - occupancy flags (registered)
module row_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] e0_q, e0_d;
    logic [WIDTH-1:0] e1_q, e1_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok;
    logic             pop_ok;

    // Next-state: shift on pop, fill first free slot on push.
    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        push_ok = push && !full_q;
        pop_ok  = pop && !empty_q;

        unique case ({push_ok, pop_ok})
            2'b10: begin
                if (empty_q) begin
                    e0_d = push_data;
                end else begin
                    e1_d = push_data;
                end
                count_d = count_q + CNT_W'(1);
            end
            2'b01: begin
                e0_d    = e1_q;
                count_d = count_q - CNT_W'(1);
            end
            // Push is blocked when full, so a simultaneous push/pop always
            // finds exactly one stored row: the new row becomes the head.
            2'b11: begin
                e0_d = push_data;
            end
            default: ;
        endcase

        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign head_data = e0_q;
    assign full      = full_q;
    assign empty     = empty_q;

endmodule

// File: rtl/column_gather.sv
// column_gather: assembles four in-order column words into one row word and
// buffers completed rows for a downstream consumer.
//   clk, reset - clock, synchronous active-high reset
//   bus        - column input / row output handshakes (column_gather_if.slave)
//   row_count  - rows consumed downstream, modulo 256
//   seq_err    - sticky out-of-order column index flag
module column_gather
    import column_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = ROW_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    column_gather_if.slave        bus,
    output logic [7:0]            row_count,
    output logic                  seq_err
);

    localparam int unsigned ROW_W = row_w(DATA_W);

    logic [COL_W-1:0]  exp_col_q, exp_col_d;
    logic [DATA_W-1:0] lane_q [3];
    logic [DATA_W-1:0] lane_d [3];
    logic [7:0]        row_count_q, row_count_d;
    logic              seq_err_q, seq_err_d;

    logic              col_xfer;
    logic              row_xfer;
    logic              push_row;
    logic [ROW_W-1:0]  push_data;
    logic              fifo_full;
    logic              fifo_empty;

    // col_ready comes straight from the FIFO's registered full flag.
    assign bus.col_ready = !fifo_full;
    assign bus.row_valid = !fifo_empty;
    assign col_xfer      = bus.col_valid && !fifo_full;
    assign row_xfer      = !fifo_empty && bus.row_ready;

    // Column 3 completes the row directly from the incoming word.
    assign push_data = {bus.col_data, lane_q[2], lane_q[1], lane_q[0]};

    // Assembly, sequence check and row counter.
    always_comb begin
        exp_col_d   = exp_col_q;
        lane_d      = lane_q;
        seq_err_d   = seq_err_q;
        row_count_d = row_count_q;
        push_row    = 1'b0;

        if (col_xfer) begin
            if (bus.col_idx == exp_col_q) begin
                unique case (bus.col_idx)
                    2'd0:    lane_d[0] = bus.col_data;
                    2'd1:    lane_d[1] = bus.col_data;
                    2'd2:    lane_d[2] = bus.col_data;
                    default: push_row  = 1'b1;
                endcase
                exp_col_d = exp_col_q + COL_W'(1);
            end else begin
                // Out of order: abandon the partial row; an idx-0 word restarts it.
                seq_err_d = 1'b1;
                if (bus.col_idx == '0) begin
                    lane_d[0] = bus.col_data;
                    exp_col_d = COL_W'(1);
                end else begin
                    exp_col_d = '0;
                end
            end
        end

        if (row_xfer) begin
            row_count_d = row_count_q + 8'(1);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            exp_col_q   <= '0;
            lane_q[0]   <= '0;
            lane_q[1]   <= '0;
            lane_q[2]   <= '0;
            row_count_q <= '0;
            seq_err_q   <= 1'b0;
        end else begin
            exp_col_q   <= exp_col_d;
            lane_q      <= lane_d;
            row_count_q <= row_count_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign row_count = row_count_q;
    assign seq_err   = seq_err_q;

    row_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_row_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_row),
        .push_data (push_data),
        .pop       (row_xfer),
        .head_data (bus.row_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: doc/column_gather.md
COLUMN_GATHER -- requirements
Module: column_gather

Interface
REQ-001 Parameter DATA_W, default 8, width of one column word.
REQ-002 Parameter FIFO_DEPTH, default 2, number of assembled rows buffered; fixed at 2 in this revision.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 col_idx  input  2  column index of the incoming word, driven by the column counter.
REQ-006 col_data  input  DATA_W  column word.
REQ-007 col_valid  input  1  col_idx/col_data valid this cycle.
REQ-008 col_ready  output  1  block accepts a column word this cycle.
REQ-009 row_data  output  4*DATA_W  assembled row; column 0 in bits [DATA_W-1:0], column 3 in the top lane.
REQ-010 row_valid  output  1  row_data holds a valid row.
REQ-011 row_ready  input  1  downstream consumes row this cycle.
REQ-012 row_count  output  8  number of rows consumed downstream (row_valid && row_ready), modulo 256.
REQ-013 seq_err  output  1  sticky flag, set on any out-of-order column index.

Function
REQ-014 A column transfer SHALL occur when col_valid && col_ready at posedge clk; a row transfer SHALL occur when row_valid && row_ready.
REQ-015 Block SHALL hold a 2-bit expected index exp_col, reset 0, and a 4-lane assembly register.
REQ-016 On a column transfer with col_idx == exp_col: col_data SHALL be written to lane col_idx, and exp_col SHALL increment, wrapping 3 -> 0.
REQ-017 On a column transfer with col_idx == 3 == exp_col: the completed row (lanes 0-2 plus the current word) SHALL be pushed into the row FIFO at that edge; row_valid SHALL rise in the next cycle if the FIFO was empty (1-cycle latency from column 3 to row_valid).
REQ-018 On a column transfer with col_idx != exp_col: seq_err SHALL set, and the partial row SHALL be discarded; if col_idx == 0, the word SHALL start a new row in lane 0 and exp_col SHALL become 1; otherwise the word SHALL be dropped and exp_col SHALL become 0.
REQ-019 col_ready SHALL be 0 exactly when the FIFO holds 2 rows; it SHALL be derived from registered state only, with no combinational path from row_ready.
REQ-020 While col_ready = 0, col_valid words SHALL be ignored, and exp_col and the lanes SHALL hold.
REQ-021 row_data/row_valid SHALL present the FIFO head; row_data SHALL remain stable while row_valid && !row_ready.
REQ-022 Simultaneous push and pop with 1 row stored SHALL leave 1 row stored, with the new row at the head next cycle; push into a full FIFO SHALL be impossible by REQ-019.
REQ-023 row_count SHALL increment by 1 per row transfer, wrapping 255 -> 0.
REQ-024 Unconsumed lanes SHALL NOT be cleared between rows; only FIFO contents are observable.

Reset
REQ-025 reset SHALL be sampled only at posedge clk, with priority over all transfers in that cycle.
REQ-026 After reset: exp_col = 0; FIFO empty; row_valid = 0; col_ready = 1; row_count = 0; seq_err = 0; row_data = 0.
REQ-027 Reset mid-row or with rows buffered SHALL discard all partial and buffered rows without emitting them.

Structure
REQ-028 Shared package column_pkg SHALL hold NUM_COLS = 4, COL_W = 2, ROW_FIFO_DEPTH = 2, and the row-word width function.
REQ-029 Row buffering SHALL be a sub-module row_fifo (2-entry, push/pop/full/empty, synchronous reset), instantiated once.
REQ-030 Column assembly, the sequence check, and the counters SHALL reside in column_gather.

Verification
REQ-031 Reset, then idx 0,1,2,3 with data 0x11,0x22,0x33,0x44, with row_ready = 1 -> next cycle row_valid = 1, row_data = 0x44332211; row_count = 1 one cycle later.
REQ-032 row_ready = 0, three full rows sent back-to-back -> col_ready falls the cycle after row 2 completes; row 3 column 0 stalls; raising row_ready drains rows 1, 2, 3 in order with no loss.
REQ-033 Send idx 0,1,3 -> seq_err = 1, no row emitted; then 0,1,2,3 -> exactly one row from the new data; seq_err stays 1.
REQ-034 Send idx 0,1,0,1,2,3 -> seq_err = 1, one row containing the second idx-0 word onward.
REQ-035 Assert reset after idx 0,1 with 1 row buffered -> row_valid = 0 next cycle; a subsequent 0..3 yields a single row, row_count = 1.
REQ-036 Stream 256 rows with row_ready = 1 -> row_count wraps to 0; no row is dropped or duplicated.
